enc_bcd_counter: RTL

Parametrised rotary-encoder step counter with a packed BCD output. It accepts single-cycle `cw`/`ccw` pulses from the quadrature decoder and converts every `PULSES_PER_STEP` net pulses into one up or down step of a `DIGITS`-digit BCD counter. The counter either wraps or saturates at its ends. It sits between the encoder decoder and the 7-segment display driver, and adds clear, load, limit flags and step strobes.

---
 rtl/enc_bcd_counter.sv | 85 ++++++++
 1 files changed

// File: rtl/enc_bcd_counter.sv
// enc_bcd_counter: rotary-encoder pulse accumulator driving a wrap/saturate BCD up/down counter
module enc_bcd_counter #(
  parameter int DIGITS          = 2,
  parameter int PULSES_PER_STEP = 4,
  parameter bit WRAP            = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cw,
  input  logic                ccw,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd_count,
  output logic                step_up,
  output logic                step_dn,
  output logic                at_max,
  output logic                at_min
);
  localparam int W = 4*DIGITS;
  localparam logic signed [8:0] PPS = 9'(PULSES_PER_STEP);
  localparam logic [W-1:0] NINES = {DIGITS{4'h9}};
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic c;
    logic [3:0] d;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      bcd_inc[4*i +: 4] = c ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
      c = c & (d == 4'd9);
    end
  endfunction
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic b;
    logic [3:0] d;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      bcd_dec[4*i +: 4] = b ? (d == 4'd0 ? 4'd9 : d - 4'd1) : d;
      b = b & (d == 4'd0);
    end
  endfunction
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++)
      bcd_clamp[4*i +: 4] = v[4*i +: 4] > 4'd9 ? 4'd9 : v[4*i +: 4];
  endfunction
  logic signed [8:0] acc, acc_inc, acc_dec, acc_nxt;
  logic up, dn;
  logic [W-1:0] count_nxt;
  assign at_max = bcd_count == NINES;
  assign at_min = bcd_count == '0;
  always_comb begin
    acc_inc   = acc + 9'sd1;
    acc_dec   = acc - 9'sd1;
    up        = cw & ~ccw & (acc_inc == PPS);
    dn        = ccw & ~cw & (acc_dec == -PPS);
    acc_nxt   = (up | dn) ? '0 : (cw & ~ccw) ? acc_inc : (ccw & ~cw) ? acc_dec : acc;
    // Saturation only matters at the ends; wrapping falls out of the ripple itself
    count_nxt = up ? ((at_max && !WRAP) ? bcd_count : bcd_inc(bcd_count)) :
                dn ? ((at_min && !WRAP) ? bcd_count : bcd_dec(bcd_count)) : bcd_count;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_count <= '0;
      acc       <= '0;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
    end else if (clr) begin
      bcd_count <= '0;
      acc       <= '0;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
    end else if (load) begin
      bcd_count <= bcd_clamp(load_val);
      acc       <= '0;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
    end else begin
      bcd_count <= count_nxt;
      acc       <= acc_nxt;
      step_up   <= up;
      step_dn   <= dn;
    end
  end
endmodule
